// File: rtl/hd_encoder_tiled_if.sv
// rtl/hd_encoder_tiled_if.sv - beat input and result output bundle for hd_encoder_tiled
interface hd_encoder_tiled_if #(
  parameter int LANES   = 32,
  parameter int NFEAT   = 32,
  parameter int FTWIDTH = 8,
  parameter int ACCW    = 16
);
  logic                       start;
  logic                       in_valid;
  logic                       in_ready;
  logic [NFEAT*FTWIDTH-1:0]   features;
  logic [LANES+NFEAT-2:0]     projections;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*ACCW-1:0]      out_acc;
  logic [LANES-1:0]           out_bin;
  logic                       busy;

  modport master (
    output start, in_valid, features, projections, out_ready,
    input  in_ready, out_valid, out_acc, out_bin, busy
  );

  modport slave (
    input  start, in_valid, features, projections, out_ready,
    output in_ready, out_valid, out_acc, out_bin, busy
  );
endinterface

// File: rtl/hd_encoder_tiled.sv
// rtl/hd_encoder_tiled.sv - LANES-wide hypervector slice encoder with saturating signed accumulators
module hd_encoder_tiled #(
  parameter int LANES     = 32,
  parameter int NFEAT     = 32,
  parameter int FTWIDTH   = 8,
  parameter int ACCW      = 16,
  parameter int NUM_BEATS = 16
) (
  input logic             clk,
  input logic             reset,
  hd_encoder_tiled_if.slave bus
);

  localparam int SW   = FTWIDTH + 1 + $clog2(NFEAT);
  localparam int SUMW = ((ACCW > SW) ? ACCW : SW) + 1;
  localparam int CW   = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_BEATS - 1);

  // Clamp bounds expressed at the widened sum width so the compare cannot overflow.
  localparam logic signed [SUMW-1:0] ACC_MAX = {{(SUMW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}};
  localparam logic signed [SUMW-1:0] ACC_MIN = {{(SUMW-ACCW+1){1'b1}}, {(ACCW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           beat_cnt;
  logic signed [ACCW-1:0]  acc     [LANES];
  logic signed [ACCW-1:0]  acc_nxt [LANES];
  logic [LANES*ACCW-1:0]   out_acc_q;
  logic [LANES-1:0]        out_bin_q;
  logic                    in_ready_c, out_valid_c, busy_c;
  logic                    accept, last_beat;

  assign accept    = (state == ACCUM) && bus.in_valid;
  assign last_beat = accept && (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ACCUM;
      ACCUM:   if (last_beat) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b1;
    case (state)
      IDLE:    busy_c = 1'b0;
      ACCUM:   in_ready_c = 1'b1;
      DONE:    out_valid_c = 1'b1;
      default: busy_c = 1'b0;
    endcase
  end

  // Lane i sees projection bits [i +: NFEAT]; each feature adds or subtracts.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [SW-1:0]   beat_sum;
    logic signed [SUMW-1:0] wide_sum;

    always_comb begin
      beat_sum = '0;
      for (int j = 0; j < NFEAT; j++) begin
        if (bus.projections[gi+j]) begin
          beat_sum = beat_sum + SW'(signed'({1'b0, bus.features[j*FTWIDTH +: FTWIDTH]}));
        end else begin
          beat_sum = beat_sum - SW'(signed'({1'b0, bus.features[j*FTWIDTH +: FTWIDTH]}));
        end
      end
    end

    assign wide_sum     = SUMW'(acc[gi]) + SUMW'(beat_sum);
    assign acc_nxt[gi]  = (wide_sum > ACC_MAX) ? ACC_MAX[ACCW-1:0] :
                          (wide_sum < ACC_MIN) ? ACC_MIN[ACCW-1:0] :
                                                 wide_sum[ACCW-1:0];
  end

  // Result registers load only with the final beat so they hold across IDLE/ACCUM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt  <= '0;
      out_acc_q <= '0;
      out_bin_q <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else if ((state == IDLE) && bus.start) begin
      beat_cnt <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else if (accept) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
      for (int i = 0; i < LANES; i++) acc[i] <= acc_nxt[i];
      if (last_beat) begin
        for (int i = 0; i < LANES; i++) begin
          out_acc_q[i*ACCW +: ACCW] <= acc_nxt[i];
          out_bin_q[i]              <= ~acc_nxt[i][ACCW-1];
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_bin   = out_bin_q;

endmodule

// File: tb/tb_hd_encoder_tiled.sv
// tb/tb_hd_encoder_tiled.sv - table-driven and randomized checks of hd_encoder_tiled
module tb_hd_encoder_tiled;

  localparam int LANES     = 32;
  localparam int NFEAT     = 32;
  localparam int FTWIDTH   = 8;
  localparam int ACCW      = 16;
  localparam int NUM_BEATS = 16;
  localparam int FW        = NFEAT * FTWIDTH;
  localparam int PW        = LANES + NFEAT - 1;
  localparam int AMAX      = (2 ** (ACCW - 1)) - 1;
  localparam int AMIN      = -(2 ** (ACCW - 1));

  logic clk;
  logic reset;

  hd_encoder_tiled_if #(.LANES(LANES), .NFEAT(NFEAT), .FTWIDTH(FTWIDTH), .ACCW(ACCW)) bus ();

  hd_encoder_tiled #(
    .LANES(LANES), .NFEAT(NFEAT), .FTWIDTH(FTWIDTH), .ACCW(ACCW), .NUM_BEATS(NUM_BEATS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               feat;
    bit               proj;
    int               stall;
    int               hold;
    bit               start_hs;
    int               exp_acc;
    logic [LANES-1:0] exp_bin;
  } vec_t;

  vec_t             tbl [7];
  logic [FW-1:0]    beat_feat [NUM_BEATS];
  logic [PW-1:0]    beat_proj [NUM_BEATS];
  int               exp_acc   [LANES];
  logic [LANES-1:0] exp_bin;
  int               checks;
  int               failures;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic fill_uniform(input int f, input bit p);
    for (int b = 0; b < NUM_BEATS; b++) begin
      for (int j = 0; j < NFEAT; j++) beat_feat[b][j*FTWIDTH +: FTWIDTH] = FTWIDTH'(f);
      beat_proj[b] = p ? {PW{1'b1}} : {PW{1'b0}};
    end
  endtask

  task automatic fill_random();
    for (int b = 0; b < NUM_BEATS; b++) begin
      for (int j = 0; j < NFEAT; j++) beat_feat[b][j*FTWIDTH +: FTWIDTH] = FTWIDTH'($urandom_range(0, 255));
      beat_proj[b] = PW'({$urandom, $urandom});
    end
  endtask

  task automatic set_expected_uniform(input int v, input logic [LANES-1:0] eb);
    for (int i = 0; i < LANES; i++) exp_acc[i] = v;
    exp_bin = eb;
  endtask

  // Integer reference: signed dot product per beat, running sum clamped after each beat.
  task automatic model_compute();
    int acc;
    int s;
    int f;
    for (int i = 0; i < LANES; i++) begin
      acc = 0;
      for (int b = 0; b < NUM_BEATS; b++) begin
        s = 0;
        for (int j = 0; j < NFEAT; j++) begin
          f = int'(beat_feat[b][j*FTWIDTH +: FTWIDTH]);
          s = beat_proj[b][i+j] ? s + f : s - f;
        end
        acc = acc + s;
        if (acc > AMAX) acc = AMAX;
        if (acc < AMIN) acc = AMIN;
      end
      exp_acc[i] = acc;
      exp_bin[i] = (acc >= 0);
    end
  endtask

  task automatic compare_outputs(input string tag);
    logic signed [ACCW-1:0] v;
    for (int i = 0; i < LANES; i++) begin
      v = bus.out_acc[i*ACCW +: ACCW];
      check($sformatf("%s_acc%0d", tag, i), v, exp_acc[i]);
    end
    check({tag, "_bin"}, bus.out_bin, exp_bin);
  endtask

  task automatic run_encode(input int stall_mode, input string tag);
    int b;
    int cyc;
    bit ready_ok;
    bit early_ok;
    bit skip;
    b = 0; cyc = 0; ready_ok = 1'b1; early_ok = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy_after_start"}, bus.busy, 1);
    while (b < NUM_BEATS && cyc < 400) begin
      if (bus.in_ready !== 1'b1) ready_ok = 1'b0;
      if (bus.out_valid !== 1'b0) early_ok = 1'b0;
      skip = (stall_mode == 1) ? cyc[0] : (stall_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (skip) begin
        bus.in_valid    = 1'b0;
        bus.features    = {FW/32{$urandom}};
        bus.projections = PW'({$urandom, $urandom});
      end else begin
        bus.in_valid    = 1'b1;
        bus.features    = beat_feat[b];
        bus.projections = beat_proj[b];
      end
      @(negedge clk);
      if (bus.in_valid) b++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    check({tag, "_beats"}, b, NUM_BEATS);
    check({tag, "_in_ready_in_accum"}, ready_ok, 1);
    check({tag, "_no_early_valid"}, early_ok, 1);
    check({tag, "_latency_out_valid"}, bus.out_valid, 1);
  endtask

  task automatic finish_result(input int hold, input bit start_hs, input string tag);
    logic [LANES*ACCW-1:0] snap;
    bit stable_ok;
    snap = bus.out_acc;
    stable_ok = 1'b1;
    for (int k = 0; k < hold; k++) begin
      bus.start = (k == hold / 2);
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_acc !== snap || bus.busy !== 1'b1) stable_ok = 1'b0;
    end
    bus.start = 1'b0;
    if (hold > 0) check({tag, "_done_hold_stable"}, stable_ok, 1);
    bus.out_ready = 1'b1;
    bus.start     = start_hs;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check({tag, "_valid_drop"}, bus.out_valid, 0);
    check({tag, "_idle_busy"}, bus.busy, 0);
    check({tag, "_acc_held_idle"}, (bus.out_acc === snap), 1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.features = '0;
    bus.projections = '0;

    tbl[0] = '{1,   1'b1, 0, 0,  1'b0,    512, {LANES{1'b1}}};
    tbl[1] = '{1,   1'b0, 0, 0,  1'b0,   -512, {LANES{1'b0}}};
    tbl[2] = '{255, 1'b1, 0, 0,  1'b0,  32767, {LANES{1'b1}}};
    tbl[3] = '{1,   1'b1, 1, 0,  1'b0,    512, {LANES{1'b1}}};
    tbl[4] = '{1,   1'b1, 0, 10, 1'b1,    512, {LANES{1'b1}}};
    tbl[5] = '{255, 1'b0, 2, 3,  1'b0, -32768, {LANES{1'b0}}};
    tbl[6] = '{0,   1'b1, 0, 0,  1'b0,      0, {LANES{1'b1}}};

    repeat (2) @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_out_acc_zero", (bus.out_acc == '0), 1);
    check("reset_out_bin", bus.out_bin, 0);
    reset = 1'b0;

    for (int t = 0; t < 7; t++) begin
      fill_uniform(tbl[t].feat, tbl[t].proj);
      set_expected_uniform(tbl[t].exp_acc, tbl[t].exp_bin);
      run_encode(tbl[t].stall, $sformatf("tbl%0d", t));
      compare_outputs($sformatf("tbl%0d", t));
      finish_result(tbl[t].hold, tbl[t].start_hs, $sformatf("tbl%0d", t));
    end

    // Positive saturation for 8 beats, then 8 beats of -8160 pull it down from the clamp.
    fill_uniform(255, 1'b1);
    for (int b = NUM_BEATS / 2; b < NUM_BEATS; b++) beat_proj[b] = '0;
    set_expected_uniform(-32513, {LANES{1'b0}});
    run_encode(0, "sat_then_neg");
    compare_outputs("sat_then_neg");
    finish_result(0, 1'b0, "sat_then_neg");

    for (int r = 0; r < 5; r++) begin
      fill_random();
      model_compute();
      run_encode(2, $sformatf("rnd%0d", r));
      compare_outputs($sformatf("rnd%0d", r));
      finish_result($urandom_range(0, 4), 1'(r & 1), $sformatf("rnd%0d", r));
    end

    // Abort after 7 beats; the previous result must vanish asynchronously.
    fill_uniform(1, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int b = 0; b < 7; b++) begin
      bus.in_valid    = 1'b1;
      bus.features    = beat_feat[b];
      bus.projections = beat_proj[b];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("abort_busy_before_reset", bus.busy, 1);
    reset = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_in_ready", bus.in_ready, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_out_acc_zero", (bus.out_acc == '0), 1);
    check("abort_out_bin", bus.out_bin, 0);
    @(negedge clk);
    reset = 1'b0;
    set_expected_uniform(512, {LANES{1'b1}});
    run_encode(0, "after_abort");
    compare_outputs("after_abort");
    finish_result(0, 1'b0, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
